// File: rtl/time_sync_table_ctrl.sv
// Double-buffered sync schedule table streamed entry by entry to the time-sync scheduler.
// Define TIME_SYNC_TABLE_RDBACK_EN to build the host read-back port on the shadow bank.
module time_sync_table_ctrl #(
    parameter int SYNC_TABLE_SIZE  = 512,
    parameter int SYNC_TS_WIDTH    = 32,
    parameter int IDENTIFIER_WIDTH = 16,
    parameter int PORT_ID_WIDTH    = 4,
    localparam int PTR_WIDTH       = $clog2(SYNC_TABLE_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sched_enable,
    input  logic                        cfg_wr_valid,
    output logic                        cfg_wr_ready,
    input  logic [PTR_WIDTH-1:0]        cfg_wr_addr,
    input  logic [SYNC_TS_WIDTH-1:0]    cfg_wr_ts,
    input  logic [IDENTIFIER_WIDTH-1:0] cfg_wr_dest_id,
    input  logic [PORT_ID_WIDTH-1:0]    cfg_wr_port,
    input  logic                        cfg_commit,
    input  logic [PTR_WIDTH:0]          cfg_commit_count,
    input  logic                        cfg_rd_valid,
    output logic                        cfg_rd_ready,
    input  logic [PTR_WIDTH-1:0]        cfg_rd_addr,
    output logic                        cfg_rd_data_valid,
    output logic [SYNC_TS_WIDTH-1:0]    cfg_rd_ts,
    output logic [IDENTIFIER_WIDTH-1:0] cfg_rd_dest_id,
    output logic [PORT_ID_WIDTH-1:0]    cfg_rd_port,
    output logic                        commit_pending,
    output logic                        cfg_err,
    output logic [PTR_WIDTH:0]          active_count,
    output logic                        ent_valid,
    input  logic                        ent_ready,
    output logic [PTR_WIDTH-1:0]        ent_index,
    output logic [SYNC_TS_WIDTH-1:0]    ent_ts,
    output logic [IDENTIFIER_WIDTH-1:0] ent_dest_id,
    output logic [PORT_ID_WIDTH-1:0]    ent_port
);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int ENT_WIDTH = SYNC_TS_WIDTH + IDENTIFIER_WIDTH + PORT_ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] SIZE_CNT = CNT_WIDTH'(SYNC_TABLE_SIZE);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [PTR_WIDTH-1:0] ptr_reg, ptr_next;
    logic                 active_bank_reg, active_bank_next;
    logic [CNT_WIDTH-1:0] active_count_reg, active_count_next;
    logic [CNT_WIDTH-1:0] pending_count_reg, pending_count_next;
    logic                 pending_reg, pending_next;
    logic                 cfg_err_reg, cfg_err_next;
    logic                 wr_ready_base_reg;

    logic [ENT_WIDTH-1:0] bank_rd_data [2];
    logic [PTR_WIDTH-1:0] bank_rd_addr [2];
    logic [ENT_WIDTH-1:0] wr_data, active_data;
    logic [CNT_WIDTH-1:0] commit_clamped, swap_count, last_idx;
    logic                 wr_accept, wr_in_range, ent_hs, at_wrap;
    logic                 swap_req, swap_now, rd_err;

    assign wr_data        = {cfg_wr_ts, cfg_wr_dest_id, cfg_wr_port};
    assign cfg_wr_ready   = wr_ready_base_reg && !pending_reg;
    assign wr_accept      = cfg_wr_valid && cfg_wr_ready;
    assign wr_in_range    = {1'b0, cfg_wr_addr} < SIZE_CNT;
    assign commit_clamped = (cfg_commit_count > SIZE_CNT) ? SIZE_CNT : cfg_commit_count;
    assign ent_hs         = (state_reg == ST_PRESENT) && ent_ready;
    assign last_idx       = active_count_reg - CNT_WIDTH'(1);
    assign at_wrap        = ({1'b0, ptr_reg} == last_idx);
    // A fresh commit in the same cycle as a pending one supersedes its count; still a single swap.
    assign swap_req       = cfg_commit || pending_reg;
    assign swap_count     = cfg_commit ? commit_clamped : pending_count_reg;
    assign swap_now       = swap_req && ((state_reg == ST_IDLE) || (ent_hs && at_wrap));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            logic [ENT_WIDTH-1:0] mem [SYNC_TABLE_SIZE];
            logic [ENT_WIDTH-1:0] rd_data_reg;
            logic                 wr_en;

            assign wr_en = wr_accept && wr_in_range && (active_bank_reg != BANK_ID);
`ifdef TIME_SYNC_TABLE_RDBACK_EN
            assign bank_rd_addr[gi] = (active_bank_reg == BANK_ID) ? ptr_reg : cfg_rd_addr;
`else
            assign bank_rd_addr[gi] = ptr_reg;
`endif
            assign bank_rd_data[gi] = rd_data_reg;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[cfg_wr_addr] <= wr_data;
                end
                rd_data_reg <= mem[bank_rd_addr[gi]];
            end
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        ptr_next           = ptr_reg;
        active_bank_next   = active_bank_reg;
        active_count_next  = active_count_reg;
        pending_next       = pending_reg;
        pending_count_next = pending_count_reg;
        cfg_err_next       = cfg_err_reg;

        if (swap_now) begin
            active_bank_next  = ~active_bank_reg;
            active_count_next = swap_count;
            pending_next      = 1'b0;
            cfg_err_next      = 1'b0;
        end else if (cfg_commit) begin
            pending_next       = 1'b1;
            pending_count_next = commit_clamped;
        end
        if ((wr_accept && !wr_in_range) || rd_err) begin
            cfg_err_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                ptr_next = '0;
                if (sched_enable && (active_count_next != '0)) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!sched_enable) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (!sched_enable) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else if (ent_ready) begin
                    ptr_next   = (at_wrap || swap_now) ? '0 : ptr_reg + PTR_WIDTH'(1);
                    state_next = (active_count_next != '0) ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            ptr_reg           <= '0;
            active_bank_reg   <= 1'b0;
            active_count_reg  <= '0;
            pending_reg       <= 1'b0;
            pending_count_reg <= '0;
            cfg_err_reg       <= 1'b0;
            wr_ready_base_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            ptr_reg           <= ptr_next;
            active_bank_reg   <= active_bank_next;
            active_count_reg  <= active_count_next;
            pending_reg       <= pending_next;
            pending_count_reg <= pending_count_next;
            cfg_err_reg       <= cfg_err_next;
            wr_ready_base_reg <= 1'b1;
        end
    end

    // The active bank's read port re-reads mem[ptr] every cycle, so fields hold while stalled.
    assign active_data    = bank_rd_data[active_bank_reg];
    assign ent_valid      = (state_reg == ST_PRESENT);
    assign ent_index      = ent_valid ? ptr_reg : '0;
    assign {ent_ts, ent_dest_id, ent_port} = ent_valid ? active_data : '0;
    assign commit_pending = pending_reg;
    assign cfg_err        = cfg_err_reg;
    assign active_count   = active_count_reg;

`ifdef TIME_SYNC_TABLE_RDBACK_EN
    logic rd_valid_reg, rd_bank_reg, rd_oor_reg;
    logic rd_accept, rd_in_range;

    assign cfg_rd_ready = !cfg_wr_valid;
    assign rd_accept    = cfg_rd_valid && cfg_rd_ready;
    assign rd_in_range  = {1'b0, cfg_rd_addr} < SIZE_CNT;
    assign rd_err       = rd_accept && !rd_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_bank_reg  <= 1'b0;
            rd_oor_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
            rd_bank_reg  <= ~active_bank_reg;
            rd_oor_reg   <= !rd_in_range;
        end
    end

    assign cfg_rd_data_valid = rd_valid_reg;
    assign {cfg_rd_ts, cfg_rd_dest_id, cfg_rd_port} =
        (rd_valid_reg && !rd_oor_reg) ? bank_rd_data[rd_bank_reg] : '0;
`else
    logic unused_rd;

    assign unused_rd         = ^{cfg_rd_valid, cfg_rd_addr};
    assign rd_err            = 1'b0;
    assign cfg_rd_ready      = 1'b0;
    assign cfg_rd_data_valid = 1'b0;
    assign cfg_rd_ts         = '0;
    assign cfg_rd_dest_id    = '0;
    assign cfg_rd_port       = '0;
`endif

endmodule
